// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and an optional 2-entry skid buffer.
// Also keeps a saturating count of back-pressured cycles for performance debug.
//
// state   | meaning
// --------+------------------------------------------
// S_EMPTY | no live bundle held
// S_ONE   | main register holds the live bundle
// S_TWO   | main and skid registers both full
module pipe_stage_skid #(
    parameter int unsigned       DATA_W    = 256,
    parameter bit                SKID_EN   = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, fire;

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = main_q;
    assign stall_cnt_o = cnt_q;
    assign fire        = out_valid_o && out_ready_i;
    assign accept      = in_valid_i && in_ready_o;

    generate
        if (SKID_EN) begin : g_skid
            // in_ready decodes registered state only, so out_ready never reaches upstream.
            assign in_ready_o = (state_q != S_TWO);

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    skid_q <= RESET_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_plain
            assign in_ready_o = !out_valid_o || out_ready_i;
            assign skid_q     = RESET_VAL;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Data registers keep their contents; out_valid alone gates their use.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data_i;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && (fire || !SKID_EN)) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = S_TWO;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_o && !out_ready_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (CNT_W=4) and a plain instance (SKID_EN=0)
// share one clock; per-instance FIFO scoreboards predict occupancy, data order, ready and stall count.
module tb_pipe_stage_skid;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [3:0]    s_cnt;

    logic          p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [DW-1:0] p_in_data, p_out_data;
    logic [15:0]   p_cnt;

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .RESET_VAL('0), .CNT_W(4)) u_skid (
        .clk_i(clk), .reset_i(rst), .flush_i(s_flush),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .stall_cnt_o(s_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .RESET_VAL('0), .CNT_W(16)) u_plain (
        .clk_i(clk), .reset_i(rst), .flush_i(p_flush),
        .in_valid_i(p_in_valid), .in_ready_o(p_in_ready), .in_data_i(p_in_data),
        .out_valid_o(p_out_valid), .out_ready_i(p_out_ready), .out_data_o(p_out_data),
        .stall_cnt_o(p_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sq[$];
    logic [DW-1:0] pq[$];
    int  s_exp_cnt = 0;
    int  p_exp_cnt = 0;
    bit  s_acc_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the models, then advance the models and the clock.
    task automatic tick();
        bit s_rdy, p_rdy;
        #1;
        s_rdy = (sq.size() < 2);
        chk("s_valid", s_out_valid, sq.size() != 0);
        chk("s_ready", s_in_ready, s_rdy);
        chk("s_cnt", s_cnt, s_exp_cnt);
        if (sq.size() != 0) chk("s_data", s_out_data, sq[0]);

        p_rdy = (pq.size() == 0) || p_out_ready;
        chk("p_valid", p_out_valid, pq.size() != 0);
        chk("p_ready", p_in_ready, p_rdy);
        chk("p_cnt", p_cnt, p_exp_cnt);
        if (pq.size() != 0) chk("p_data", p_out_data, pq[0]);

        if (sq.size() != 0 && !s_out_ready && s_exp_cnt < 15) s_exp_cnt++;
        if (sq.size() != 0 && s_out_ready) void'(sq.pop_front());
        s_acc_last = s_in_valid && s_rdy && !s_flush;
        if (s_flush) sq.delete();
        else if (s_in_valid && s_rdy) sq.push_back(s_in_data);

        if (pq.size() != 0 && !p_out_ready && p_exp_cnt < 65535) p_exp_cnt++;
        if (pq.size() != 0 && p_out_ready) void'(pq.pop_front());
        if (p_flush) pq.delete();
        else if (p_in_valid && p_rdy) pq.push_back(p_in_data);

        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
        p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0; p_in_data = '0;
        #1;
        chk("init_s_valid", s_out_valid, 1'b0);
        chk("init_s_ready", s_in_ready, 1'b1);
        chk("init_s_data", s_out_data, 0);
        chk("init_p_ready", p_in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming on both instances
        s_out_ready = 1'b1;
        p_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_in_valid = 1'b1; s_in_data = DW'(32'h10 + i);
            p_in_valid = 1'b1; p_in_data = DW'(32'h20 + i);
            tick();
            chk("stream_s_acc", s_acc_last, 1'b1);
        end
        s_in_valid = 1'b0; p_in_valid = 1'b0;
        repeat (2) tick();
        p_out_ready = 1'b0;

        // Skid fill and drain
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hA1; tick();
        s_in_data = 32'hA2; tick();
        s_in_data = 32'hA3;
        repeat (3) tick();
        chk("a3_held", s_in_ready, 1'b0);
        s_out_ready = 1'b1;
        budget = 0;
        s_acc_last = 1'b0;
        while (!s_acc_last && budget < 10) begin
            tick();
            budget++;
        end
        chk("a3_accepted", s_acc_last, 1'b1);
        s_in_valid = 1'b0;
        repeat (4) tick();
        chk("skid_stall_total", s_cnt, 4'd4);

        // Flush from TWO with in_valid
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hB1; tick();
        s_in_data = 32'hB2; tick();
        s_flush = 1'b1; s_in_data = 32'hB5; tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        chk("flush_valid", s_out_valid, 1'b0);
        chk("flush_ready", s_in_ready, 1'b1);
        s_out_ready = 1'b1;
        repeat (3) tick();

        // Flush from ONE discards a concurrent accept
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hC1; tick();
        s_flush = 1'b1; s_in_data = 32'hC2; tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        repeat (2) tick();

        // Flush with concurrent fire still delivers the firing entry
        s_in_valid = 1'b1; s_in_data = 32'hD1; tick();
        s_flush = 1'b1; s_in_data = 32'hD2; tick();
        s_flush = 1'b0; s_in_valid = 1'b0;
        repeat (2) tick();

        // Stall counter saturation
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hE1; tick();
        s_in_valid = 1'b0;
        repeat (20) tick();
        chk("stall_saturated", s_cnt, 4'hF);

        // Asynchronous reset mid-cycle while in TWO
        s_in_valid = 1'b1; s_in_data = 32'hE2; tick();
        s_in_valid = 1'b0;
        chk("pre_rst_two", s_in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_s_valid", s_out_valid, 1'b0);
        chk("rst_s_data", s_out_data, 0);
        chk("rst_s_ready", s_in_ready, 1'b1);
        chk("rst_s_cnt", s_cnt, 0);
        chk("rst_p_valid", p_out_valid, 1'b0);
        sq.delete(); pq.delete();
        s_exp_cnt = 0; p_exp_cnt = 0;
        #1;
        rst = 1'b0;
        s_out_ready = 1'b1;
        tick();

        // Plain register: combinational in_ready
        p_out_ready = 1'b0;
        p_in_valid = 1'b1; p_in_data = 32'h51; tick();
        p_in_data = 32'h52;
        #2;
        chk("plain_blocked", p_in_ready, 1'b0);
        p_out_ready = 1'b1;
        #1;
        chk("plain_released", p_in_ready, 1'b1);
        p_out_ready = 1'b0;
        tick();
        p_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p_in_valid = 1'b1; p_in_data = DW'(32'h60 + i);
            tick();
        end
        p_in_valid = 1'b0;
        repeat (2) tick();
        chk("plain_empty", p_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
